flash_fetch_arbiter: RTL and testbench

Shares the single QSPI read channel between two requesters: the video instruction stream (4-deep data_buffer chain feeding instruction_decoder) and the PWM audio sample stream. Issues bounded burst reads with word addresses to qspi_controller and tracks one wrapping read pointer per stream. Routes each returned 20-bit word to the requester that owns the current burst. Sits between qspi_controller and the two consumers in tt_um_jonathan_thing_vga.

---
 rtl/flash_fetch_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_flash_fetch_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_fetch_arbiter.sv
// Shares the QSPI read channel between the video instruction stream and the audio sample stream.
// Issues bounded, region-wrapping bursts and steers returned words to the owning stream.
module flash_fetch_arbiter #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned WORD_W    = 20,
    parameter int unsigned VID_BASE  = 0,
    parameter int unsigned VID_WORDS = 1048576,
    parameter int unsigned AUD_BASE  = 1048576,
    parameter int unsigned AUD_WORDS = 65536,
    parameter int unsigned VID_BURST = 4,
    parameter int unsigned AUD_BURST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        vid_free,
    input  logic              vid_rewind,
    input  logic              aud_req,
    input  logic              fl_busy,
    input  logic              fl_word_valid,
    input  logic [WORD_W-1:0] fl_word,
    output logic              fl_start,
    output logic [ADDR_W-1:0] fl_addr,
    output logic [3:0]        fl_len,
    output logic              vid_word_valid,
    output logic              aud_word_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              owner_aud
);

    localparam logic [ADDR_W-1:0] VID_FIRST = ADDR_W'(VID_BASE);
    localparam logic [ADDR_W-1:0] VID_LAST  = ADDR_W'(VID_BASE + VID_WORDS - 1);
    localparam logic [ADDR_W-1:0] AUD_FIRST = ADDR_W'(AUD_BASE);
    localparam logic [ADDR_W-1:0] AUD_LAST  = ADDR_W'(AUD_BASE + AUD_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        XFER      = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   vid_ptr_q, vid_ptr_d;
    logic [ADDR_W-1:0]   aud_ptr_q, aud_ptr_d;
    logic [3:0]          rem_q, rem_d;
    logic                rew_pend_q, rew_pend_d;
    logic                fl_start_q, fl_start_d;
    logic [ADDR_W-1:0]   fl_addr_q, fl_addr_d;
    logic [3:0]          fl_len_q, fl_len_d;
    logic                vid_wv_q, vid_wv_d;
    logic                aud_wv_q, aud_wv_d;
    logic [WORD_W-1:0]   out_word_q, out_word_d;
    logic                owner_aud_q, owner_aud_d;

    logic [31:0]         vid_room_c, aud_room_c;
    logic [31:0]         vid_len_c, aud_len_c;
    logic                word_ok_c;
    logic                vid_want_c, aud_grant_c;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p,
                                                   input logic [ADDR_W-1:0] first,
                                                   input logic [ADDR_W-1:0] last);
        return (p == last) ? first : p + ADDR_W'(1);
    endfunction

    // Burst lengths: clipped to burst cap, buffer space (video) and distance to region end.
    always_comb begin
        vid_room_c = 32'(VID_LAST - vid_ptr_q) + 32'd1;
        aud_room_c = 32'(AUD_LAST - aud_ptr_q) + 32'd1;
        vid_len_c  = 32'(VID_BURST);
        if (32'(vid_free) < vid_len_c) vid_len_c = 32'(vid_free);
        if (vid_room_c < vid_len_c)    vid_len_c = vid_room_c;
        aud_len_c  = 32'(AUD_BURST);
        if (aud_room_c < aud_len_c)    aud_len_c = aud_room_c;
    end

    assign vid_want_c  = (vid_free != 3'd0);
    assign aud_grant_c = aud_req && !(vid_want_c && owner_aud_q);
    assign word_ok_c   = fl_word_valid && (state_q != IDLE) && (rem_q != 4'd0);

    always_comb begin
        state_d     = state_q;
        vid_ptr_d   = vid_ptr_q;
        aud_ptr_d   = aud_ptr_q;
        rem_d       = rem_q;
        rew_pend_d  = rew_pend_q;
        fl_start_d  = 1'b0;
        fl_addr_d   = fl_addr_q;
        fl_len_d    = fl_len_q;
        vid_wv_d    = 1'b0;
        aud_wv_d    = 1'b0;
        out_word_d  = out_word_q;
        owner_aud_d = owner_aud_q;

        if (word_ok_c) begin
            out_word_d = fl_word;
            rem_d      = rem_q - 4'd1;
            if (owner_aud_q) begin
                aud_wv_d  = 1'b1;
                aud_ptr_d = wrap_inc(aud_ptr_q, AUD_FIRST, AUD_LAST);
            end else begin
                vid_wv_d  = 1'b1;
                vid_ptr_d = wrap_inc(vid_ptr_q, VID_FIRST, VID_LAST);
            end
        end

        // A rewind during a video burst is deferred so in-flight increments cannot undo it.
        if (state_q != IDLE && vid_rewind) begin
            if (owner_aud_q) vid_ptr_d  = VID_FIRST;
            else             rew_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (vid_rewind) begin
                    vid_ptr_d = VID_FIRST;
                end else if (aud_grant_c) begin
                    state_d     = ISSUE;
                    fl_start_d  = 1'b1;
                    fl_addr_d   = aud_ptr_q;
                    fl_len_d    = 4'(aud_len_c);
                    rem_d       = 4'(aud_len_c);
                    owner_aud_d = 1'b1;
                end else if (vid_want_c) begin
                    state_d     = ISSUE;
                    fl_start_d  = 1'b1;
                    fl_addr_d   = vid_ptr_q;
                    fl_len_d    = 4'(vid_len_c);
                    rem_d       = 4'(vid_len_c);
                    owner_aud_d = 1'b0;
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (fl_busy) state_d = XFER;
            XFER: begin
                if (rem_q == 4'd0 && !fl_busy) begin
                    state_d    = IDLE;
                    rew_pend_d = 1'b0;
                    if (!owner_aud_q && (rew_pend_q || vid_rewind)) vid_ptr_d = VID_FIRST;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vid_ptr_q   <= VID_FIRST;
            aud_ptr_q   <= AUD_FIRST;
            rem_q       <= 4'd0;
            rew_pend_q  <= 1'b0;
            fl_start_q  <= 1'b0;
            fl_addr_q   <= '0;
            fl_len_q    <= 4'd0;
            vid_wv_q    <= 1'b0;
            aud_wv_q    <= 1'b0;
            out_word_q  <= '0;
            owner_aud_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vid_ptr_q   <= vid_ptr_d;
            aud_ptr_q   <= aud_ptr_d;
            rem_q       <= rem_d;
            rew_pend_q  <= rew_pend_d;
            fl_start_q  <= fl_start_d;
            fl_addr_q   <= fl_addr_d;
            fl_len_q    <= fl_len_d;
            vid_wv_q    <= vid_wv_d;
            aud_wv_q    <= aud_wv_d;
            out_word_q  <= out_word_d;
            owner_aud_q <= owner_aud_d;
        end
    end

    assign fl_start       = fl_start_q;
    assign fl_addr        = fl_addr_q;
    assign fl_len         = fl_len_q;
    assign vid_word_valid = vid_wv_q;
    assign aud_word_valid = aud_wv_q;
    assign out_word       = out_word_q;
    assign owner_aud      = owner_aud_q;

endmodule

// File: tb/tb_flash_fetch_arbiter.sv
// Directed bench for flash_fetch_arbiter: a small flash responder plus a word scoreboard.
module tb_flash_fetch_arbiter;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned WORD_W = 20;
    localparam int unsigned ABASE  = 1048576;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        vid_free;
    logic              vid_rewind;
    logic              aud_req;
    logic              fl_busy;
    logic              fl_word_valid;
    logic [WORD_W-1:0] fl_word;
    logic              fl_start;
    logic [ADDR_W-1:0] fl_addr;
    logic [3:0]        fl_len;
    logic              vid_word_valid;
    logic              aud_word_valid;
    logic [WORD_W-1:0] out_word;
    logic              owner_aud;

    int n_chk  = 0;
    int n_fail = 0;
    logic [WORD_W:0] exp_q[$];
    logic fwv_prev = 1'b0;

    always #20 clk = ~clk;

    flash_fetch_arbiter #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W),
        .VID_BASE(0), .VID_WORDS(10),
        .AUD_BASE(ABASE), .AUD_WORDS(5),
        .VID_BURST(4), .AUD_BURST(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_free(vid_free), .vid_rewind(vid_rewind), .aud_req(aud_req),
        .fl_busy(fl_busy), .fl_word_valid(fl_word_valid), .fl_word(fl_word),
        .fl_start(fl_start), .fl_addr(fl_addr), .fl_len(fl_len),
        .vid_word_valid(vid_word_valid), .aud_word_valid(aud_word_valid),
        .out_word(out_word), .owner_aud(owner_aud)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] pat(input int a, input int i);
        return WORD_W'((a + i) * 13 + 5) ^ 20'h5A5A5;
    endfunction

    // Scoreboard: each delivered word must match the oldest word the responder sent.
    always @(negedge clk) begin
        if (rst_n && (vid_word_valid || aud_word_valid)) begin
            chk("one_hot_valid", 32'(vid_word_valid ^ aud_word_valid), 32'd1);
            chk("valid_latency", 32'(fwv_prev), 32'd1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_word: observed 0x%0h expected no word", out_word);
            end else begin
                logic [WORD_W:0] e;
                e = exp_q.pop_front();
                chk("word_owner", 32'(aud_word_valid), 32'(e[WORD_W]));
                chk("word_data", 32'(out_word), 32'(e[WORD_W-1:0]));
            end
        end
        fwv_prev <= fl_word_valid;
    end

    task automatic wait_start(input bit ea, input int eaddr, input int elen, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = fl_start;
        end
        chk("start_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("fl_addr", 32'(fl_addr), 32'(eaddr));
            chk("fl_len", 32'(fl_len), 32'(elen));
            chk("owner_aud", 32'(owner_aud), 32'(ea));
        end
    endtask

    task automatic run_burst(input bit ea, input int eaddr, input int elen,
                             input bit stop, input bit rew);
        bit seen;
        wait_start(ea, eaddr, elen, seen);
        if (!seen) return;
        @(posedge clk); #1;
        fl_busy = 1'b1;
        if (stop) begin
            vid_free = 3'd0;
            aud_req  = 1'b0;
        end
        @(negedge clk);
        chk("start_pulse", 32'(fl_start), 32'd0);
        for (int i = 0; i < elen; i++) begin
            @(posedge clk); #1;
            fl_word_valid = 1'b1;
            fl_word       = pat(eaddr, i);
            vid_rewind    = rew && (i == 0);
            exp_q.push_back({ea, pat(eaddr, i)});
        end
        @(posedge clk); #1;
        fl_word_valid = 1'b0;
        vid_rewind    = 1'b0;
        fl_busy       = 1'b0;
        @(negedge clk);
        chk("fl_addr_hold", 32'(fl_addr), 32'(eaddr));
        chk("fl_len_hold", 32'(fl_len), 32'(elen));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; vid_free = 3'd0; vid_rewind = 1'b0; aud_req = 1'b0;
        fl_busy = 1'b0; fl_word_valid = 1'b0; fl_word = '0;
        repeat (2) @(negedge clk);
        chk("rst_fl_start", 32'(fl_start), 32'd0);
        chk("rst_fl_addr", 32'(fl_addr), 32'd0);
        chk("rst_fl_len", 32'(fl_len), 32'd0);
        chk("rst_valids", 32'({vid_word_valid, aud_word_valid}), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);
        chk("rst_owner", 32'(owner_aud), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Stray word while idle is dropped.
        @(posedge clk); #1; fl_word_valid = 1'b1; fl_word = 20'hABCDE;
        @(posedge clk); #1; fl_word_valid = 1'b0;
        @(negedge clk);
        chk("stray_valids", 32'({vid_word_valid, aud_word_valid}), 32'd0);
        chk("stray_out_word", 32'(out_word), 32'd0);
        chk("stray_no_start", 32'(fl_start), 32'd0);

        // Single video burst of 4.
        vid_free = 3'd4;
        run_burst(1'b0, 0, 4, 1'b1, 1'b0);

        // Both requesting: alternation, audio and video region-end clipping and wrap.
        vid_free = 3'd3; aud_req = 1'b1;
        run_burst(1'b1, ABASE,     2, 1'b0, 1'b0);
        run_burst(1'b0, 4,         3, 1'b0, 1'b0);
        run_burst(1'b1, ABASE + 2, 2, 1'b0, 1'b0);
        run_burst(1'b0, 7,         3, 1'b0, 1'b0);
        run_burst(1'b1, ABASE + 4, 1, 1'b0, 1'b0);
        run_burst(1'b0, 0,         3, 1'b0, 1'b0);
        run_burst(1'b1, ABASE,     2, 1'b1, 1'b0);

        // Video alone: region end clips burst, then wraps to base.
        vid_free = 3'd4; run_burst(1'b0, 3, 4, 1'b1, 1'b0);
        vid_free = 3'd4; run_burst(1'b0, 7, 3, 1'b1, 1'b0);
        vid_free = 3'd4; run_burst(1'b0, 0, 4, 1'b1, 1'b0);
        vid_free = 3'd2; run_burst(1'b0, 4, 2, 1'b1, 1'b0);

        // Rewind during video burst at pointer 6: applied on return to idle.
        vid_free = 3'd2; run_burst(1'b0, 6, 2, 1'b1, 1'b1);
        vid_free = 3'd1; run_burst(1'b0, 0, 1, 1'b1, 1'b0);

        // Rewind together with a request in idle: rewind wins, grant one cycle later.
        @(posedge clk); #1; vid_free = 3'd4; vid_rewind = 1'b1;
        @(posedge clk); #1; vid_rewind = 1'b0;
        @(negedge clk);
        chk("rewind_delays_grant", 32'(fl_start), 32'd0);
        run_burst(1'b0, 0, 4, 1'b1, 1'b0);

        // Rewind during an audio burst takes effect immediately.
        aud_req = 1'b1;
        run_burst(1'b1, ABASE + 2, 2, 1'b1, 1'b1);
        vid_free = 3'd4; run_burst(1'b0, 0, 4, 1'b1, 1'b0);

        // Reset in the middle of a video burst after 2 of 4 words.
        vid_free = 3'd4;
        wait_start(1'b0, 4, 4, seen);
        @(posedge clk); #1; vid_free = 3'd0; fl_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            fl_word_valid = 1'b1;
            fl_word       = pat(4, i);
            exp_q.push_back({1'b0, pat(4, i)});
        end
        @(posedge clk); #1; fl_word_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0; fl_busy = 1'b0;
        @(negedge clk);
        chk("midrst_valids", 32'({vid_word_valid, aud_word_valid}), 32'd0);
        chk("midrst_fl_start", 32'(fl_start), 32'd0);
        chk("midrst_fl_len", 32'(fl_len), 32'd0);
        chk("midrst_owner", 32'(owner_aud), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1; vid_free = 3'd4; aud_req = 1'b1;
        run_burst(1'b1, ABASE, 2, 1'b0, 1'b0);
        run_burst(1'b0, 0,     4, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("final_no_start", 32'(fl_start), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
